gnrl_sgnl_pulse_meter: RTL and testbench

Measurement counterpart to the pulse delay/widen generator. After an arm pulse, it counts clock cycles until the selected-polarity leading edge of a monitored signal, then counts that pulse's width in cycles. It reports both values with a one-cycle done strobe, plus timeout and width-overflow flags. It is used to self-check generated pulses and to time external strobes in the same clock domain.

---
 rtl/gnrl_sgnl_pulse_meter.sv | 111 +++++++++++
 tb/tb_gnrl_sgnl_pulse_meter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gnrl_sgnl_pulse_meter.sv
// Pulse meter: after an arm pulse, counts cycles to the leading edge of the
// selected-polarity pulse on sig_i, then counts that pulse's width.
module gnrl_sgnl_pulse_meter #(
  parameter int DW = 12,
  parameter int WW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm_i,
  input  logic          sig_i,
  input  logic          polarity,
  input  logic [DW-1:0] timeout_num,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] delay_o,
  output logic [WW-1:0] width_o,
  output logic          timeout_o,
  output logic          ovf_o
);

  typedef enum logic [1:0] {IDLE, WAIT, MEASURE, DONE} state_t;

  localparam logic [DW-1:0] DMAX = '1;
  localparam logic [WW-1:0] WMAX = '1;

  state_t        state, state_nx;
  logic          sig_d, pol_r, ovf_r;
  logic [DW-1:0] dcnt, delay_r;
  logic [WW-1:0] wcnt;
  logic          act, act_d, lead, trail, to_hit;

  // Active level follows the polarity latched at arm, not the live input.
  assign act    = ~(sig_i ^ pol_r);
  assign act_d  = ~(sig_d ^ pol_r);
  assign lead   = act & ~act_d;
  assign trail  = ~act & act_d;
  assign to_hit = (timeout_num != '0) && (dcnt == timeout_num);

  assign busy_o = (state == WAIT) || (state == MEASURE);
  assign done_o = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      WAIT: begin
        if (lead)        state_nx = MEASURE;
        else if (to_hit) state_nx = DONE;
      end
      MEASURE: if (trail) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // arm wins over every state action, including the DONE cycle
    if (arm_i) state_nx = WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sig_d     <= 1'b0;
      pol_r     <= 1'b0;
      ovf_r     <= 1'b0;
      dcnt      <= '0;
      delay_r   <= '0;
      wcnt      <= '0;
      delay_o   <= '0;
      width_o   <= '0;
      timeout_o <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      state <= state_nx;
      sig_d <= sig_i;
      if (arm_i) begin
        pol_r <= polarity;
        dcnt  <= {{(DW-1){1'b0}}, 1'b1};
        wcnt  <= '0;
        ovf_r <= 1'b0;
      end else begin
        case (state)
          WAIT: begin
            if (lead) begin
              delay_r <= dcnt;
              wcnt    <= {{(WW-1){1'b0}}, 1'b1};
            end else if (to_hit) begin
              delay_o   <= timeout_num;
              width_o   <= '0;
              timeout_o <= 1'b1;
              ovf_o     <= 1'b0;
            end else if (dcnt != DMAX) begin
              dcnt <= dcnt + 1'b1;
            end
          end
          MEASURE: begin
            if (trail) begin
              delay_o   <= delay_r;
              width_o   <= wcnt;
              timeout_o <= 1'b0;
              ovf_o     <= ovf_r;
            end else if (act) begin
              if (wcnt == WMAX) ovf_r <= 1'b1;
              else              wcnt  <= wcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gnrl_sgnl_pulse_meter.sv
// Bench for gnrl_sgnl_pulse_meter: directed and randomized pulses checked
// against an arithmetic model of delay, width, timeout and saturation.
module tb_gnrl_sgnl_pulse_meter;

  localparam int DW = 12;
  localparam int WW = 5;
  localparam int WMAXI = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst, arm_i, sig_i, polarity;
  logic [DW-1:0] timeout_num;
  logic          busy_o, done_o, timeout_o, ovf_o;
  logic [DW-1:0] delay_o;
  logic [WW-1:0] width_o;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  gnrl_sgnl_pulse_meter #(.DW(DW), .WW(WW)) dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .sig_i(sig_i), .polarity(polarity),
    .timeout_num(timeout_num), .busy_o(busy_o), .done_o(done_o),
    .delay_o(delay_o), .width_o(width_o), .timeout_o(timeout_o), .ovf_o(ovf_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arm at sample 0 with the signal inactive, active pulse covering samples
  // d .. d+w-1. The model predicts the result from d, w and tnum directly.
  task automatic run_meas(input logic pol, input int d, input int w, input int tnum,
                          input string tag);
    int e, got;
    logic [DW-1:0] ed;
    logic [WW-1:0] ew;
    logic et, eo;
    if (tnum != 0 && d > tnum) begin
      e = tnum; ed = DW'(tnum); ew = '0; et = 1'b1; eo = 1'b0;
    end else begin
      e = d + w; ed = DW'(d); ew = WW'((w > WMAXI) ? WMAXI : w);
      et = 1'b0; eo = (w > WMAXI);
    end
    polarity = pol; timeout_num = DW'(tnum); sig_i = ~pol; arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    polarity = 1'($urandom);
    vecs++;
    if (busy_o !== 1'b1) begin
      errs++; $display("FAIL %s busy_after_arm: got %b want 1", tag, busy_o);
    end
    got = -1;
    for (int k = 1; k <= e + 4 && got < 0; k++) begin
      sig_i = (k >= d && k < d + w) ? pol : ~pol;
      tick();
      if (done_o === 1'b1) got = k;
    end
    vecs++;
    if (got != e) begin
      errs++; $display("FAIL %s done_sample: got %0d want %0d", tag, got, e);
    end
    vecs++;
    if ({busy_o, delay_o, width_o, timeout_o, ovf_o} !== {1'b0, ed, ew, et, eo}) begin
      errs++;
      $display("FAIL %s result: got busy=%b d=%0d w=%0d to=%b ovf=%b want busy=0 d=%0d w=%0d to=%b ovf=%b",
               tag, busy_o, delay_o, width_o, timeout_o, ovf_o, ed, ew, et, eo);
    end
    sig_i = ~pol;
    tick();
    vecs++;
    if ({done_o, busy_o, delay_o, width_o, timeout_o, ovf_o} !== {2'b00, ed, ew, et, eo}) begin
      errs++;
      $display("FAIL %s after_done: got done=%b busy=%b d=%0d w=%0d want done=0 busy=0 held d=%0d w=%0d",
               tag, done_o, busy_o, delay_o, width_o, ed, ew);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arm_i = 1'b0; sig_i = 1'b1; polarity = 1'b1; timeout_num = '0;
    tick(); tick();
    vecs++;
    if ({done_o, busy_o, delay_o, width_o, timeout_o, ovf_o} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got done=%b busy=%b d=%0d w=%0d to=%b ovf=%b want all 0",
               done_o, busy_o, delay_o, width_o, timeout_o, ovf_o);
    end
    rst = 1'b0; sig_i = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_meas(1'b1, 5, 3, 0, "high_pulse");
    run_meas(1'b0, 2, 1, 0, "low_pulse");
    run_meas(1'b1, 100, 1, 10, "timeout");
    run_meas(1'b1, 3, 40, 0, "width_ovf");
    run_meas(1'b1, 1, 31, 0, "width_max");
    run_meas(1'b0, 7, 32, 7, "edge_at_limit");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int tn;
      tn = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 70));
      run_meas(1'($urandom), int'($urandom_range(1, 60)), int'($urandom_range(1, 45)), tn, "random");
    end
  endtask

  // Re-arm in the middle of a pulse: that pulse is already active at the
  // new arm, so only the following pulse is measured.
  task automatic test_rearm();
    int seq[7] = '{1, 1, 1, 0, 1, 1, 0};
    logic early_done;
    run_meas(1'b1, 3, 2, 0, "rearm_pre");
    early_done = 1'b0;
    arm_i = 1'b1; sig_i = 1'b0; polarity = 1'b1; timeout_num = '0;
    tick();
    arm_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      sig_i = (k >= 4);
      tick();
      if (done_o === 1'b1) early_done = 1'b1;
    end
    arm_i = 1'b1; sig_i = 1'b1;
    tick();
    arm_i = 1'b0;
    vecs++;
    if ({busy_o, delay_o, width_o, timeout_o, ovf_o} !== {1'b1, 12'd3, 5'd2, 2'b00}) begin
      errs++;
      $display("FAIL rearm_hold: got busy=%b d=%0d w=%0d to=%b ovf=%b want busy=1 d=3 w=2 to=0 ovf=0",
               busy_o, delay_o, width_o, timeout_o, ovf_o);
    end
    for (int k = 1; k <= 7; k++) begin
      sig_i = (seq[k-1] != 0);
      tick();
      if (k < 7 && done_o === 1'b1) early_done = 1'b1;
    end
    vecs++;
    if (early_done !== 1'b0) begin
      errs++; $display("FAIL rearm_early_done: got 1 want 0");
    end
    vecs++;
    if ({done_o, delay_o, width_o, timeout_o, ovf_o} !== {1'b1, 12'd5, 5'd2, 2'b00}) begin
      errs++;
      $display("FAIL rearm_result: got done=%b d=%0d w=%0d to=%b ovf=%b want done=1 d=5 w=2 to=0 ovf=0",
               done_o, delay_o, width_o, timeout_o, ovf_o);
    end
    sig_i = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    logic seen_done;
    seen_done = 1'b0;
    arm_i = 1'b1; sig_i = 1'b0; polarity = 1'b1; timeout_num = '0;
    tick();
    arm_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      sig_i = (k >= 3);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({done_o, busy_o, delay_o, width_o, timeout_o, ovf_o} !== '0) begin
      errs++;
      $display("FAIL rst_mid_outputs: got done=%b busy=%b d=%0d w=%0d to=%b ovf=%b want all 0",
               done_o, busy_o, delay_o, width_o, timeout_o, ovf_o);
    end
    tick();
    sig_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done_o === 1'b1) seen_done = 1'b1;
    end
    vecs++;
    if ({seen_done, busy_o} !== 2'b00) begin
      errs++; $display("FAIL rst_mid_no_done: got done_seen=%b busy=%b want 0 0", seen_done, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    run_meas(1'b0, 4, 6, 0, "b2b_a");
    run_meas(1'b1, 1, 1, 1, "b2b_b");
    run_meas(1'b1, 2, 3, 1, "b2b_timeout_1");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_rearm();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
